// File: rtl/proc_clock_sequencer.sv
// proc_clock_sequencer: derives the processor skeleton clocks from the master clock with run/halt/step control
module proc_clock_sequencer #(
    parameter int PERIOD    = 4,
    parameter bit RESET_RUN = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             run_en,
    input  logic             step,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             processor_clock,
    output logic             regfile_clock,
    output logic             running,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             count_wrap
);
    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] H    = PW'(PERIOD / 2);
    localparam logic [PW-1:0] Q    = PW'(PERIOD / 4);
    localparam logic [PW-1:0] QH   = PW'(PERIOD / 4 + PERIOD / 2);

    typedef enum logic [1:0] {HALTED, RUN, STEP} state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic          active;
    logic          at_wrap;

    assign active  = state != HALTED;
    assign at_wrap = ph == LAST;

    // sequencer FSM, phase counter, derived clocks and retired-cycle counter
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state           <= RESET_RUN ? RUN : HALTED;
            running         <= RESET_RUN;
            ph              <= '0;
            imem_clock      <= 1'b0;
            dmem_clock      <= 1'b0;
            processor_clock <= 1'b0;
            regfile_clock   <= 1'b0;
            step_done       <= 1'b0;
            cycle_count     <= '0;
            count_wrap      <= 1'b0;
        end else begin
            step_done       <= 1'b0;
            imem_clock      <= active && ph < H;
            dmem_clock      <= active && ph >= Q && ph < QH;
            processor_clock <= active && ph >= H;
            regfile_clock   <= active && ph >= H;
            ph              <= (active && !at_wrap) ? ph + 1'b1 : '0;
            case (state)
                HALTED: begin
                    if (run_en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (step) begin
                        state   <= STEP;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (at_wrap && !run_en) begin
                        state   <= HALTED;
                        running <= 1'b0;
                    end
                end
                STEP: begin
                    if (at_wrap) begin
                        state     <= run_en ? RUN : HALTED;
                        running   <= run_en;
                        step_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= HALTED;
                    running <= 1'b0;
                end
            endcase
            if (active && ph == H) begin
                cycle_count <= cycle_count + 1'b1;
                if (&cycle_count)
                    count_wrap <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_proc_clock_sequencer.sv
// tb_proc_clock_sequencer: directed tests of run, halt, step, wrap and async reset behaviour
module tb_proc_clock_sequencer;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic run_a = 1'b1, step_a = 1'b0, run_b = 1'b0, step_b = 1'b0;
    logic ia, da, pa, ra, runa, sda, wa;
    logic ib, db, pb, rb, runb, sdb, wb;
    logic [3:0]  cnta;
    logic [31:0] cntb;
    int tests = 0;
    int fails = 0;

    proc_clock_sequencer #(.PERIOD(4), .RESET_RUN(1'b1), .CNT_W(4)) dut_a (
        .clock(clock), .ctrl_reset(rst_n), .run_en(run_a), .step(step_a),
        .imem_clock(ia), .dmem_clock(da), .processor_clock(pa), .regfile_clock(ra),
        .running(runa), .step_done(sda), .cycle_count(cnta), .count_wrap(wa)
    );

    proc_clock_sequencer #(.PERIOD(4), .RESET_RUN(1'b0), .CNT_W(32)) dut_b (
        .clock(clock), .ctrl_reset(rst_n), .run_en(run_b), .step(step_b),
        .imem_clock(ib), .dmem_clock(db), .processor_clock(pb), .regfile_clock(rb),
        .running(runb), .step_done(sdb), .cycle_count(cntb), .count_wrap(wb)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++;
        if ({ia, da, pa, ra, sda, wa, cnta} !== 10'b0) begin
            fails++;
            $display("FAIL reset_a_outputs got=%b want=0", {ia, da, pa, ra, sda, wa, cnta});
        end
        tests++;
        if (runa !== 1'b1) begin
            fails++;
            $display("FAIL reset_a_running got=%b want=1", runa);
        end
        tests++;
        if ({ib, db, pb, rb, sdb, wb, runb} !== 7'b0 || cntb !== 32'd0) begin
            fails++;
            $display("FAIL reset_b_outputs got=%b cnt=%0d want=0", {ib, db, pb, rb, sdb, wb, runb}, cntb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        for (int k = 1; k <= 16; k++) begin
            int p;
            logic [3:0] e;
            tick();
            p = (k - 1) % 4;
            e = {p < 2, p >= 1 && p < 3, p >= 2, p >= 2};
            tests++;
            if ({ia, da, pa, ra} !== e) begin
                fails++;
                $display("FAIL run_wave edge=%0d got=%b want=%b", k, {ia, da, pa, ra}, e);
            end
        end
        tests++;
        if (cnta !== 4'd4) begin
            fails++;
            $display("FAIL run_count got=%0d want=4", cnta);
        end
        tests++;
        if ({ib, db, pb, rb, runb} !== 5'b0) begin
            fails++;
            $display("FAIL halted_b_quiet got=%b want=0", {ib, db, pb, rb, runb});
        end
    endtask

    task automatic test_drop_run();
        tick();
        run_a = 1'b0;
        tick();
        tests++;
        if (pa !== 1'b0) begin
            fails++;
            $display("FAIL drop_ph1 proc got=%b want=0", pa);
        end
        tick();
        tests++;
        if (pa !== 1'b1 || cnta !== 4'd5) begin
            fails++;
            $display("FAIL drop_ph2 proc=%b cnt=%0d want proc=1 cnt=5", pa, cnta);
        end
        tick();
        tests++;
        if (pa !== 1'b1 || runa !== 1'b0) begin
            fails++;
            $display("FAIL drop_ph3 proc=%b running=%b want proc=1 running=0", pa, runa);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if ({ia, da, pa, ra, runa} !== 5'b0) begin
                fails++;
                $display("FAIL drop_halted k=%0d got=%b want=0", k, {ia, da, pa, ra, runa});
            end
        end
        tests++;
        if (cnta !== 4'd5) begin
            fails++;
            $display("FAIL drop_count got=%0d want=5", cnta);
        end
    endtask

    task automatic test_step();
        int highs = 0, pulses = 0, pulse_at = -1, first_hi = -1, late = 0;
        step_b = 1'b1;
        tick();
        step_b = 1'b0;
        tests++;
        if (runb !== 1'b1) begin
            fails++;
            $display("FAIL step_running got=%b want=1", runb);
        end
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (pb) begin
                highs++;
                if (first_hi < 0) first_hi = i;
            end
            if (sdb) begin
                pulses++;
                pulse_at = i;
            end
            if (i > 5 && {ib, db, pb, rb} !== 4'b0) late++;
        end
        tests++;
        if (highs !== 2 || first_hi !== 3) begin
            fails++;
            $display("FAIL step_proc highs=%0d first=%0d want highs=2 first=3", highs, first_hi);
        end
        tests++;
        if (pulses !== 1 || pulse_at !== 4) begin
            fails++;
            $display("FAIL step_done pulses=%0d at=%0d want pulses=1 at=4", pulses, pulse_at);
        end
        tests++;
        if (late !== 0 || runb !== 1'b0) begin
            fails++;
            $display("FAIL step_quiet late=%0d running=%b want late=0 running=0", late, runb);
        end
        tests++;
        if (cntb !== 32'd1) begin
            fails++;
            $display("FAIL step_count got=%0d want=1", cntb);
        end
    endtask

    task automatic test_step_and_run();
        int highs = 0, pulses = 0, stopped = 0;
        step_a = 1'b1;
        run_a  = 1'b1;
        tick();
        step_a = 1'b0;
        tests++;
        if (runa !== 1'b1) begin
            fails++;
            $display("FAIL both_running got=%b want=1", runa);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (pa) highs++;
            if (sda) pulses++;
            if (!runa) stopped++;
        end
        tests++;
        if (highs !== 8 || stopped !== 0) begin
            fails++;
            $display("FAIL both_clocking highs=%0d stopped=%0d want highs=8 stopped=0", highs, stopped);
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL both_step_done got=%0d want=0", pulses);
        end
        tests++;
        if (cnta !== 4'd9) begin
            fails++;
            $display("FAIL both_count got=%0d want=9", cnta);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8 && !pa; i++) tick();
        tests++;
        if (pa !== 1'b1) begin
            fails++;
            $display("FAIL async_setup proc got=%b want=1", pa);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ia, da, pa, ra} !== 4'b0 || cnta !== 4'd0) begin
            fails++;
            $display("FAIL async_immediate clocks=%b cnt=%0d want 0", {ia, da, pa, ra}, cnta);
        end
        tick();
        tests++;
        if ({ia, da, pa, ra, wa} !== 5'b0 || cnta !== 4'd0) begin
            fails++;
            $display("FAIL async_held clocks=%b wrap=%b cnt=%0d want 0", {ia, da, pa, ra}, wa, cnta);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        int highs = 0, pulses = 0;
        for (int k = 1; k <= 68; k++) begin
            if (k == 20) step_a = 1'b1;
            if (k == 21) step_a = 1'b0;
            tick();
            if (pa) highs++;
            if (sda) pulses++;
            if (k == 60) begin
                tests++;
                if (cnta !== 4'd15 || wa !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_before cnt=%0d wrap=%b want cnt=15 wrap=0", cnta, wa);
                end
            end
            if (k == 63) begin
                tests++;
                if (cnta !== 4'd0 || wa !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_at cnt=%0d wrap=%b want cnt=0 wrap=1", cnta, wa);
                end
            end
        end
        tests++;
        if (cnta !== 4'd1 || wa !== 1'b1) begin
            fails++;
            $display("FAIL wrap_after cnt=%0d wrap=%b want cnt=1 wrap=1", cnta, wa);
        end
        tests++;
        if (highs !== 34 || pulses !== 0 || runa !== 1'b1) begin
            fails++;
            $display("FAIL wrap_step_ignored highs=%0d pulses=%0d running=%b want 34/0/1", highs, pulses, runa);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_drop_run();
        test_step();
        test_step_and_run();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
